// File: rtl/mmio_timer_if.sv
// mmio_timer_if: data-bus responder signals between the core initiator and the timer.
interface mmio_timer_if;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [3:0]  write_mask;
   logic        write_enable;
   logic        read_enable;
   logic [31:0] read_data;
   logic        read_valid;
   logic        irq;
   modport master (output address, write_data, write_mask, write_enable, read_enable,
                   input read_data, read_valid, irq);
   modport slave  (input address, write_data, write_mask, write_enable, read_enable,
                   output read_data, read_valid, irq);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 64-bit prescaled timer with compare, sticky match and level irq.
// Define MMIO_TIMER_LATCH_EN to latch MTIME[63:32] on a MTIME_LO read for atomic 64-bit reads.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'hB000_0000,
   parameter int          PRESCALE_W = 16
) (
   input logic         clk_i,
   input logic         rst_ni,
   mmio_timer_if.slave bus
);
   logic [2:0]            ctrl_q, ctrl_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;
   logic [63:0]           mtime_q, mtime_d, mtime_t, cmp_q, cmp_d;
   logic                  match_q, match_d, irq_q, rvalid_q;
   logic [31:0]           rdata_q, rdat, hi_rd;
   logic                  hit, wr, rd, tick, per_hit, unused_addr;
   logic [2:0]            off;
   logic [31:0]           wd;
   logic [3:0]            m;

   function automatic logic [31:0] bmask(input logic [31:0] o, input logic [31:0] n, input logic [3:0] k);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i+:8] = k[i] ? n[8*i+:8] : o[8*i+:8];
      return r;
   endfunction

   assign hit         = bus.address[31:5] == BASE_ADDR[31:5];
   assign off         = bus.address[4:2];
   assign unused_addr = ^bus.address[1:0];
   assign wr          = bus.write_enable & hit;
   assign rd          = bus.read_enable & hit;
   assign wd          = bus.write_data;
   assign m           = bus.write_mask;

`ifdef MMIO_TIMER_LATCH_EN
   logic [31:0] shadow_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) shadow_q <= '0;
      else if (rd && off == 3'd2) shadow_q <= mtime_q[63:32];
   assign hi_rd = shadow_q;
`else
   assign hi_rd = mtime_q[63:32];
`endif

   always_comb begin
      tick    = ctrl_q[0] & (pcnt_q == pre_q);
      per_hit = tick & ctrl_q[1] & (mtime_q == cmp_q);
      ctrl_d  = (wr && off == 3'd0 && m[0]) ? wd[2:0] : ctrl_q;
      pre_d   = (wr && off == 3'd1) ? PRESCALE_W'(bmask(32'(pre_q), wd, m)) : pre_q;
      pcnt_d  = (!ctrl_q[0] || tick || (wr && off == 3'd1)) ? '0 : pcnt_q + 1'b1;
      mtime_t = !tick ? mtime_q : per_hit ? '0 : mtime_q + 64'd1;
      // A software write to one half wins over the tick and leaves the other half untouched.
      mtime_d = (wr && off == 3'd2) ? {mtime_q[63:32], bmask(mtime_q[31:0], wd, m)} :
                (wr && off == 3'd3) ? {bmask(mtime_q[63:32], wd, m), mtime_q[31:0]} : mtime_t;
      cmp_d   = (wr && off == 3'd4) ? {cmp_q[63:32], bmask(cmp_q[31:0], wd, m)} :
                (wr && off == 3'd5) ? {bmask(cmp_q[63:32], wd, m), cmp_q[31:0]} : cmp_q;
      match_d = per_hit | (ctrl_q[0] & ~ctrl_q[1] & (mtime_q >= cmp_q)) |
                (match_q & ~(wr && off == 3'd6 && m[0] && wd[0]));
      rdat    = off == 3'd0 ? {29'd0, ctrl_q} :
                off == 3'd1 ? 32'(pre_q) :
                off == 3'd2 ? mtime_q[31:0] :
                off == 3'd3 ? hi_rd :
                off == 3'd4 ? cmp_q[31:0] :
                off == 3'd5 ? cmp_q[63:32] :
                off == 3'd6 ? {31'd0, match_q} : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         ctrl_q   <= '0;
         pre_q    <= '0;
         pcnt_q   <= '0;
         mtime_q  <= '0;
         cmp_q    <= '1;
         match_q  <= 1'b0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         pre_q    <= pre_d;
         pcnt_q   <= pcnt_d;
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         match_q  <= match_d;
         irq_q    <= match_q & ctrl_q[2];
         rvalid_q <= rd;
         if (rd) rdata_q <= rdat;
      end

   assign bus.read_data  = rdata_q;
   assign bus.read_valid = rvalid_q;
   assign bus.irq        = irq_q;
endmodule
